// File: rtl/pe_sched_pkg.sv
// Shared constants for the PE operation scheduler: opcodes, FSM state
// encoding and the instruction width.
package pe_sched_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [3:0] OP_MAC  = 4'h1;
  localparam logic [3:0] OP_ACT  = 4'h2;
  localparam logic [3:0] OP_NORM = 4'h3;
  localparam logic [3:0] OP_MEM  = 4'h4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_HOLD  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } sched_state_e;

  // Opcode field of an instruction word.
  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/pe_sched_fifo.sv
// Synchronous instruction FIFO for the scheduler. Read data is presented
// combinationally from the head entry; a push while full is taken only when
// a pop happens in the same cycle, so the occupancy never exceeds DEPTH.
module pe_sched_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign rd_en      = pop_i && !empty_o;
  assign wr_en      = push_i && (!full_o || rd_en);
  assign full_o     = (count == (AW + 1)'(DEPTH));
  assign empty_o    = (count == '0);
  assign pop_data_o = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/pe_op_scheduler.sv
// PE operation scheduler: round-robin arbitration of NUM_REQ instruction
// requesters into a FIFO, then one-at-a-time issue to pe_top with per-opcode
// hold latency, memory-ack wait with timeout, and tagged completion pulses.
// Optional performance counters are compiled in with PE_SCHED_PERF_CNT_EN.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clock edge where valid and ready are both 1. req_ready_o is a
// combinational grant, one-hot or zero, and never depends on it being taken.
module pe_op_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAC_LAT     = 2,
  parameter int unsigned ACT_LAT     = 1,
  parameter int unsigned NORM_LAT    = 3,
  parameter int unsigned MEM_TIMEOUT = 255,
  localparam int unsigned TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr_i,
  output logic                       pe_valid_o,
  output logic [INSTR_W-1:0]         pe_instr_o,
  input  logic                       pe_ready_i,
  input  logic                       mem_ack_i,
  output logic                       done_valid_o,
  output logic [TAG_W-1:0]           done_tag_o,
  output logic                       done_err_o,
  output logic                       busy_o,
  output logic [2:0]                 dbg_state_o
`ifdef PE_SCHED_PERF_CNT_EN
  ,
  input  logic                       perf_clr_i,
  output logic [31:0]                perf_busy_cycles_o,
  output logic [31:0]                perf_ops_o,
  output logic [15:0]                perf_err_o
`endif
);

  localparam int unsigned ENT_W = TAG_W + INSTR_W;

  // The shared counter must reach both the largest hold count and the
  // memory timeout value.
  localparam int unsigned LAT_MAX_A = (MAC_LAT > ACT_LAT) ? MAC_LAT : ACT_LAT;
  localparam int unsigned LAT_MAX   = (LAT_MAX_A > NORM_LAT) ? LAT_MAX_A : NORM_LAT;
  localparam int unsigned CNT_MAX   = (LAT_MAX > MEM_TIMEOUT) ? LAT_MAX : MEM_TIMEOUT;
  localparam int unsigned CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  sched_state_e state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               err_q, err_n;

  logic [TAG_W-1:0]   rr_ptr;
  logic               grant_vld;
  logic [TAG_W-1:0]   grant_idx;
  logic [TAG_W-1:0]   cand;
  logic [INSTR_W-1:0] grant_instr;
  logic [INSTR_W-1:0] req_instr_a [NUM_REQ];

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENT_W-1:0]   fifo_dout;
  logic [TAG_W-1:0]   fifo_tag;
  logic [INSTR_W-1:0] fifo_instr;

  logic [TAG_W-1:0]   issue_tag;
  logic [INSTR_W-1:0] issue_instr;

  // Hold count loaded on PE acceptance: latency minus one, latency 0 acts as 1.
  function automatic logic [CNT_W-1:0] hold_init(input logic [3:0] op);
    int unsigned lat;
    case (op)
      OP_MAC:  lat = MAC_LAT;
      OP_ACT:  lat = ACT_LAT;
      default: lat = NORM_LAT;
    endcase
    if (lat == 0) lat = 1;
    return CNT_W'(lat - 1);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_instr_a[g] = req_instr_i[g*INSTR_W +: INSTR_W];
  end

  // Round-robin grant: first valid requester at or after rr_ptr, only when
  // the FIFO has room.
  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    grant_instr = '0;
    cand        = '0;
    req_ready_o = '0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = TAG_W'((32'(rr_ptr) + i) % NUM_REQ);
        if (!grant_vld && req_valid_i[cand]) begin
          grant_vld   = 1'b1;
          grant_idx   = cand;
          grant_instr = req_instr_a[cand];
        end
      end
    end
    if (grant_vld) req_ready_o[grant_idx] = 1'b1;
  end

  // Round-robin pointer advances past the requester that just transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  pe_sched_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (grant_vld),
    .push_data_i ({grant_idx, grant_instr}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_dout),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign {fifo_tag, fifo_instr} = fifo_dout;

  // FSM state, shared latency/timeout counter and completion error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  // Issue register: captured on pop, held through IDLE/DONE so pe_instr_o
  // only changes when a new op is dequeued.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_tag   <= '0;
      issue_instr <= '0;
    end else if (fifo_pop) begin
      issue_tag   <= fifo_tag;
      issue_instr <= fifo_instr;
    end
  end

  // Next-state and PE/completion strobes.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    err_n        = err_q;
    fifo_pop     = 1'b0;
    pe_valid_o   = 1'b0;
    done_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pe_valid_o = 1'b1;
        if (pe_ready_i) begin
          err_n = 1'b0;
          if (instr_opcode(issue_instr) == OP_MEM) begin
            state_n = S_MEM;
            cnt_n   = '0;
          end else begin
            state_n = S_HOLD;
            cnt_n   = hold_init(instr_opcode(issue_instr));
          end
        end
      end
      S_HOLD: begin
        pe_valid_o = 1'b1;
        if (cnt == '0) state_n = S_DONE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      S_MEM: begin
        pe_valid_o = 1'b1;
        if (mem_ack_i) begin
          state_n = S_DONE;
          err_n   = 1'b0;
        end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        done_valid_o = 1'b1;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign pe_instr_o  = issue_instr;
  assign done_tag_o  = (state == S_DONE) ? issue_tag : '0;
  assign done_err_o  = (state == S_DONE) && err_q;
  assign busy_o      = !fifo_empty || (state != S_IDLE);
  assign dbg_state_o = state;

`ifdef PE_SCHED_PERF_CNT_EN
  logic in_busy_state;
  assign in_busy_state = (state == S_ISSUE) || (state == S_HOLD) || (state == S_MEM);

  // Saturating performance counters; a clear request beats any increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr_i) begin
      perf_busy_cycles_o <= '0;
      perf_ops_o         <= '0;
      perf_err_o         <= '0;
    end else begin
      if (in_busy_state && (perf_busy_cycles_o != '1))
        perf_busy_cycles_o <= perf_busy_cycles_o + 32'd1;
      if (done_valid_o && (perf_ops_o != '1))
        perf_ops_o <= perf_ops_o + 32'd1;
      if (done_err_o && (perf_err_o != '1))
        perf_err_o <= perf_err_o + 16'd1;
    end
  end
`endif

endmodule
